// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder: state encodings and width helpers.
package serial_bit_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Gap counter holds GAP-1, and GAP never exceeds 15.
    localparam int unsigned GAP_CNT_W = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned log2w(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: takes WIDTH-bit words on valid/ready and drives them
// one bit per clock onto x, with an optional forced idle gap between words.
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 0,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int unsigned          CW       = log2w(WIDTH);
    localparam logic [CW-1:0]        LAST     = CW'(WIDTH - 1);
    localparam bit                   HAS_GAP  = (GAP != 0);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = HAS_GAP ? GAP_CNT_W'(GAP - 1) : '0;

    state_t                 state, state_n;
    logic [WIDTH-1:0]       sreg, sreg_n, sreg_shifted;
    logic [CW-1:0]          cnt, cnt_n;
    logic [GAP_CNT_W-1:0]   gcnt, gcnt_n;
    logic                   last_bit;
    logic                   accept;

    // Outputs decoded from registered state only; x is a mux of registers, so it
    // falls back to IDLE_LEVEL the moment reset forces the state to IDLE.
    always_comb begin
        last_bit  = (state == ST_SHIFT) && (cnt == LAST);
        x_valid   = (state == ST_SHIFT);
        sof       = x_valid && (cnt == '0);
        eof       = last_bit;
        busy      = (state != ST_IDLE);
        din_ready = rst && ((state == ST_IDLE) || (last_bit && !HAS_GAP));
        x         = IDLE_LEVEL;
        if (x_valid) begin
            x = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        end
    end

    // Next-state, shift and counter update.
    always_comb begin
        state_n      = state;
        sreg_n       = sreg;
        cnt_n        = cnt;
        gcnt_n       = gcnt;
        accept       = din_valid && din_ready;
        sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SHIFT;
                    sreg_n  = din;
                    cnt_n   = '0;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    if (HAS_GAP) begin
                        state_n = ST_GAP;
                        gcnt_n  = GAP_LOAD;
                    end else if (accept) begin
                        sreg_n = din;
                        cnt_n  = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    sreg_n = sreg_shifted;
                    cnt_n  = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    gcnt_n = gcnt - 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
            gcnt  <= gcnt_n;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: three configurations run side by side,
// a driver per instance pushes expected bits on accept, one monitor pops and compares.
module tb_serial_bit_feeder;

    localparam int NI = 3;

    typedef struct {
        bit b;
        bit s;
        bit e;
        int c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0, din1;
    logic [4:0] din2;
    logic       dv[NI], rdy[NI], xo[NI], xv[NI], sf[NI], ef[NI], bz[NI];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   next_ok[NI];
    int   busy_until[NI];
    exp_t expq[NI][$];
    exp_t me;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b1)) u0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(dv[0]), .din_ready(rdy[0]),
        .x(xo[0]), .x_valid(xv[0]), .sof(sf[0]), .eof(ef[0]), .busy(bz[0])
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2), .IDLE_LEVEL(1'b1)) u1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(dv[1]), .din_ready(rdy[1]),
        .x(xo[1]), .x_valid(xv[1]), .sof(sf[1]), .eof(ef[1]), .busy(bz[1])
    );

    serial_bit_feeder #(.WIDTH(5), .MSB_FIRST(1'b1), .GAP(1), .IDLE_LEVEL(1'b0)) u2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(dv[2]), .din_ready(rdy[2]),
        .x(xo[2]), .x_valid(xv[2]), .sof(sf[2]), .eof(ef[2]), .busy(bz[2])
    );

    function automatic int wid(int i);
        case (i)
            0: return 8;
            1: return 8;
            default: return 5;
        endcase
    endfunction

    function automatic int gp(int i);
        case (i)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit msbf(int i);
        return (i != 1);
    endfunction

    function automatic bit idl(int i);
        return (i != 2);
    endfunction

    task automatic chk(string nm, int i, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0d expected=%0d", nm, i, cyc, act, exp);
        end
    endtask

    task automatic set_din(int i, logic [31:0] w);
        case (i)
            0: din0 = w[7:0];
            1: din1 = w[7:0];
            default: din2 = w[4:0];
        endcase
    endtask

    // Reference: word accepted at edge n occupies cycles n..n+W-1 bit by bit;
    // the next accept is possible on the last bit (no gap) or after gap + one idle cycle.
    task automatic record(int i, logic [31:0] w, int n);
        int   W;
        exp_t e;
        W = wid(i);
        for (int k = 0; k < W; k++) begin
            e.b = msbf(i) ? w[W-1-k] : w[k];
            e.s = (k == 0);
            e.e = (k == W - 1);
            e.c = n + k;
            expq[i].push_back(e);
        end
        next_ok[i]    = (gp(i) == 0) ? n + W - 1 : n + W + gp(i);
        busy_until[i] = n + W + gp(i);
    endtask

    // Present a word and hold it until the block takes it.
    task automatic send(int i, logic [31:0] w);
        logic r;
        int   c;
        bit   done;
        done = 1'b0;
        set_din(i, w);
        dv[i] = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            r = rdy[i];
            c = cyc;
            @(posedge clk);
            if (r) begin
                record(i, w, c + 1);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", i, 0, 1);
        #1;
        dv[i] = 1'b0;
    endtask

    task automatic idle(int i, int g);
        repeat (g) begin
            set_din(i, $urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(int i);
        logic [31:0] dw[8];
        int          dg[8];
        dw = '{32'hA5, 32'hF0, 32'h0F, 32'h81, 32'h81, 32'h01, 32'hFF, 32'h00};
        dg = '{2, 2, 0, 3, 0, 2, 2, 0};
        for (int k = 0; k < 8; k++) begin
            idle(i, dg[k]);
            send(i, dw[k]);
        end
        for (int k = 0; k < 25; k++) begin
            idle(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3)));
            send(i, $urandom);
        end
    endtask

    // Monitor: every cycle, each output must match the scoreboard head or the idle line.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                if (expq[i].size() > 0 && expq[i][0].c == cyc) begin
                    me = expq[i].pop_front();
                    chk("x_valid", i, xv[i], 1);
                    chk("x_bit", i, xo[i], me.b);
                    chk("sof", i, sf[i], me.s);
                    chk("eof", i, ef[i], me.e);
                end else begin
                    chk("x_valid_idle", i, xv[i], 0);
                    chk("x_idle_level", i, xo[i], idl(i));
                    chk("sof_idle", i, sf[i], 0);
                    chk("eof_idle", i, ef[i], 0);
                end
                chk("din_ready", i, rdy[i], (cyc >= next_ok[i]) ? 1 : 0);
                chk("busy", i, bz[i], (cyc < busy_until[i]) ? 1 : 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        din0 = '0;
        din1 = '0;
        din2 = '0;
        for (int i = 0; i < NI; i++) begin
            dv[i]         = 1'b0;
            next_ok[i]    = 0;
            busy_until[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_x", i, xo[i], idl(i));
            chk("rst_x_valid", i, xv[i], 0);
            chk("rst_sof", i, sf[i], 0);
            chk("rst_eof", i, ef[i], 0);
            chk("rst_busy", i, bz[i], 0);
            chk("rst_din_ready", i, rdy[i], 0);
        end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        fork
            drive(0);
            drive(1);
            drive(2);
        join
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk("drain", i, expq[i].size(), 0);

        // Reset in the middle of a word: 8'h55 interrupted while bit 3 is on the line.
        send(0, 32'h55);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("midrst_x", i, xo[i], idl(i));
            chk("midrst_x_valid", i, xv[i], 0);
            chk("midrst_busy", i, bz[i], 0);
            chk("midrst_din_ready", i, rdy[i], 0);
        end
        for (int i = 0; i < NI; i++) begin
            expq[i].delete();
            next_ok[i]    = 0;
            busy_until[i] = 0;
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        fork
            send(0, $urandom);
            send(1, $urandom);
            send(2, $urandom);
        join
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk("drain_after_rst", i, expq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage that sits directly upstream of the zero-detector Moore FSM.
- Accepts WIDTH-bit words on a valid/ready handshake.
- Drives them one bit per clock onto the serial line that the detector samples as its x input.
- Between words it holds the line at an idle level and can insert a programmable inter-word gap.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- GAP, 0: idle cycles forced between the last bit of one word and the first bit of the next; legal range 0..15.
- IDLE_LEVEL, 1: value driven on x when no bit is being sent.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- din  input  WIDTH  parallel word to serialise
- din_valid  input  1  din holds a word to send
- din_ready  output  1  block can accept din this cycle
- x  output  1  serial bit to the zero detector; registered
- x_valid  output  1  x carries a data bit this cycle
- sof  output  1  x is the first bit of a word
- eof  output  1  x is the last bit of a word
- busy  output  1  state is not IDLE

Behaviour:
- Reset: clk is a single clock; rst is asynchronous and active-low.
  - While rst = 0: state = IDLE, shift register = 0, bit counter = 0, gap counter = 0.
  - Output values under reset: x = IDLE_LEVEL, x_valid = 0, sof = 0, eof = 0, busy = 0, din_ready = 0.
  - din_ready rises combinationally from state once rst = 1.
- Accept: a word is taken on a rising edge where din_valid = 1 and din_ready = 1. din is captured into the shift register on that edge.
- Latency: a word accepted at edge N puts its first bit on x from edge N until edge N+1. Its last bit is on x from edge N+WIDTH-1 until edge N+WIDTH. That is exactly WIDTH consecutive x_valid cycles.
- States (binary encoded, 2 bits):
  - IDLE: x = IDLE_LEVEL, x_valid = 0, din_ready = 1. On accept -> SHIFT, counter = 0.
  - SHIFT: x = current bit, x_valid = 1. The counter advances each cycle. sof = 1 when the counter is 0; eof = 1 when the counter is WIDTH-1. On the eof cycle:
    - GAP > 0: go to GAP state, gap counter = GAP-1.
    - GAP = 0 and accept: stay in SHIFT with the new word, counter = 0 (back-to-back, no bubble).
    - GAP = 0 and no accept: go to IDLE.
  - GAP: x = IDLE_LEVEL, x_valid = 0, din_ready = 0. The gap counter decrements each cycle; at 0, go to IDLE. GAP cycles plus one IDLE cycle separate words.
- din_ready is combinational from state and counter only, never from din_valid: it is (state==IDLE) or (state==SHIFT and eof and GAP==0).
- Bit order: MSB_FIRST=1 shifts left and emits sreg[WIDTH-1]. MSB_FIRST=0 shifts right and emits sreg[0].
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1 and wraps to 0 only on a back-to-back accept.
- din_valid asserted while din_ready = 0 has no effect. The word is not captured, and upstream must hold it.
- din changing while in SHIFT does not disturb the word in flight.
- Reset mid-word: the partial word is discarded, x returns to IDLE_LEVEL immediately, and nothing is resumed after reset.
- sof and eof are both 1 in the same cycle only if WIDTH = 1, which is illegal.

Decomposition:
- Shared package holds the state encodings IDLE = 2'b00, SHIFT = 2'b01 and GAP = 2'b10, plus a log2 width constant function.
- No sub-module: the shift register, bit counter and gap counter live in one module.

Test Plan:
- WIDTH=8, MSB_FIRST=1, GAP=0: din=8'hA5 pulsed one cycle -> x = 1,0,1,0,0,1,0,1 over 8 cycles; sof on bit 0, eof on bit 7; then IDLE with x = 1 and din_ready = 1.
- Back-to-back, GAP=0: din_valid held high with 8'hF0 then 8'h0F -> 16 consecutive x_valid cycles, x = 1111000000001111, and din_ready = 1 exactly on the two eof cycles.
- GAP=2: two words 8'h81, 8'h81 -> after the first eof, x = 1 with x_valid = 0 for 2 GAP cycles plus 1 IDLE cycle; the second sof appears 4 cycles after the first eof.
- MSB_FIRST=0: din=8'h01 -> x = 1,0,0,0,0,0,0,0.
- Hold-off: din_valid = 1 with din=8'h00 during SHIFT of 8'hFF -> no capture until din_ready; the serial stream is 8 ones then 8 zeros.
- Reset mid-word: rst low at bit 3 of 8'h55 -> x = 1, x_valid = 0 and busy = 0 asynchronously; after release the first accepted word starts with sof and a fresh count.
